// File: rtl/pool_reader.sv
// pool_reader
// Streams the contents of the maxpool output buffer to the dense stage.
// Reads are issued to the synchronous buffer port only when a FIFO slot is
// already reserved for the returning word. The word arrives READ_LATENCY edges
// after the read is sampled, so the FIFO can never overflow.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous reset, active low
//   start      in   one-cycle request to stream the whole buffer (idle only)
//   pool_addr  out  buffer read address (linear index)
//   pool_en    out  buffer read strobe
//   pool_q     in   buffer read data, READ_LATENCY edges after pool_en
//   out_data   out  stream payload (FIFO head)
//   out_valid  out  payload valid (FIFO non-empty)
//   out_ready  in   downstream accept
//   out_last   out  high with the beat at index TOTAL-1
//   busy       out  high from start acceptance through the done cycle
//   done       out  one-cycle pulse after the final beat transfers
module pool_reader #(
  parameter int DATA_WIDTH   = 16,
  parameter int CHANNELS     = 1,
  parameter int SIZE         = 2,
  parameter int READ_LATENCY = 1,
  localparam int TOTAL       = CHANNELS * SIZE * SIZE,
  localparam int AW          = (TOTAL <= 1) ? 1 : $clog2(TOTAL)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic [AW-1:0]                pool_addr,
  output logic                         pool_en,
  input  logic signed [DATA_WIDTH-1:0] pool_q,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
);

  localparam int FDEPTH = READ_LATENCY + 1;
  localparam int PW     = (FDEPTH <= 2) ? 1 : $clog2(FDEPTH);
  localparam int CW     = $clog2(FDEPTH + 1);
  // Index counters must also represent TOTAL itself ("all reads issued").
  localparam int IW     = $clog2(TOTAL + 1);

  localparam logic [IW-1:0] TOTAL_IDX = IW'(TOTAL);
  localparam logic [IW-1:0] LAST_IDX  = IW'(TOTAL - 1);
  localparam logic [PW-1:0] PTR_MAX   = PW'(FDEPTH - 1);
  localparam logic [CW:0]   CREDITS   = (CW + 1)'(FDEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                       r_state;
  logic [READ_LATENCY-1:0]      r_tag;      // one bit per read still in the buffer pipeline
  logic signed [DATA_WIDTH-1:0] r_mem [FDEPTH];
  logic [PW-1:0]                r_wr_ptr;
  logic [PW-1:0]                r_rd_ptr;
  logic [CW-1:0]                r_fcount;
  logic [IW-1:0]                r_idx;      // next read index
  logic [IW-1:0]                r_beat;     // index of the beat at the FIFO head

  logic                         w_push;
  logic                         w_pop;
  logic                         w_issue;
  logic [CW-1:0]                w_inflight;
  logic [CW:0]                  w_credits;
  logic [READ_LATENCY-1:0]      w_tag_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PW'(1);
  endfunction

  // A returning word is captured on the edge where its tag leaves the pipeline.
  assign w_push = r_tag[READ_LATENCY-1];
  assign w_pop  = (r_fcount != '0) && out_ready;

  generate
    if (READ_LATENCY == 1) begin : g_tag1
      assign w_tag_next = w_issue;
    end else begin : g_tagn
      assign w_tag_next = {r_tag[READ_LATENCY-2:0], w_issue};
    end
  endgenerate

  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < READ_LATENCY; k++) begin
      w_inflight = w_inflight + CW'(r_tag[k]);
    end
    // Slots committed after this edge's pop; a pop only happens when the
    // FIFO is non-empty, so this never underflows.
    w_credits = {1'b0, r_fcount} + {1'b0, w_inflight} - {{CW{1'b0}}, w_pop};
    w_issue   = (r_state == S_RUN) && (r_idx < TOTAL_IDX) && (w_credits < CREDITS);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_tag    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fcount <= '0;
      r_idx    <= '0;
      r_beat   <= '0;
      for (int k = 0; k < FDEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      r_tag <= w_tag_next;

      if (w_push) begin
        r_mem[r_wr_ptr] <= pool_q;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end

      unique case ({w_push, w_pop})
        2'b10:   r_fcount <= r_fcount + CW'(1);
        2'b01:   r_fcount <= r_fcount - CW'(1);
        default: r_fcount <= r_fcount;
      endcase

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_idx   <= '0;
            r_beat  <= '0;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_idx <= r_idx + IW'(1);
          end
          if (w_pop) begin
            r_beat <= r_beat + IW'(1);
            if (r_beat == LAST_IDX) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pool_en   = w_issue;
  assign pool_addr = r_idx[AW-1:0];
  assign out_data  = r_mem[r_rd_ptr];
  assign out_valid = (r_fcount != '0);
  assign out_last  = out_valid && (r_beat == LAST_IDX);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule
